seg7_reader: RTL and testbench
==============================

SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, the number of consecutive identical valid samples required to accept a pattern (legal range 1..255).
REQ-002 SHALL have port clock  input  1  the single rising-edge clock for all state.
REQ-003 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port seg_in  input  7  active-low segment pattern; bit0 = segment a ... bit6 = segment g.
REQ-005 SHALL have port seg_valid  input  1  seg_in is meaningful this cycle.
REQ-006 SHALL have port digit  output  4  recovered hex value.
REQ-007 SHALL have port digit_valid  output  1  digit is offered, held until consumed.
REQ-008 SHALL have port digit_ready  input  1  consumer accepts digit when digit_valid=1 and digit_ready=1.
REQ-009 SHALL have port pat_err  output  1  one-cycle pulse: a stable pattern matched no hex glyph.
REQ-010 SHALL have port digit_count  output  8  number of digits accepted by the consumer, saturating at 255.

Function
REQ-011 SHALL decode active-low patterns (hex, g..a): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E; all other patterns are invalid.
REQ-012 SHALL implement states IDLE, TRACK, HOLD, WAIT_CHANGE with a registered current-pattern register cur_pat and 8-bit stability counter stab_cnt.
REQ-013 IDLE: on seg_valid=1, cur_pat<=seg_in, stab_cnt<=1, go TRACK (if STABLE_CYCLES=1, evaluate immediately as in REQ-015).
REQ-014 TRACK: seg_valid=0 -> IDLE, stab_cnt<=0; seg_in!=cur_pat -> cur_pat<=seg_in, stab_cnt<=1; seg_in==cur_pat -> stab_cnt increments.
REQ-015 Acceptance when stab_cnt reaches STABLE_CYCLES: valid glyph -> digit latched, HOLD; invalid glyph -> pat_err=1 for the next cycle only, WAIT_CHANGE.
REQ-016 Latency: pattern first sampled at edge N and unchanged -> digit_valid=1 after edge N+STABLE_CYCLES-1.
REQ-017 HOLD: digit and digit_valid=1 stable until handshake; seg_in/seg_valid ignored; on handshake digit_valid<=0, digit_count increments (saturating), go WAIT_CHANGE.
REQ-018 WAIT_CHANGE: remain while seg_valid=1 and seg_in==cur_pat (no re-accept, no repeated pat_err); seg_valid=0 -> IDLE; seg_in!=cur_pat -> cur_pat<=seg_in, stab_cnt<=1, TRACK.
REQ-019 digit_ready while digit_valid=0 SHALL have no effect.
REQ-020 pat_err and digit_valid SHALL never assert in the same cycle.
REQ-021 digit_count at 255 SHALL stay 255 on further handshakes.

Reset
REQ-022 resetn=0 SHALL immediately force IDLE, cur_pat=7'h7F, stab_cnt=0, digit=0, digit_valid=0, pat_err=0, digit_count=0, regardless of clock or state, including mid-HOLD (pending digit discarded).
REQ-023 After resetn deasserts, first sampling edge SHALL behave as IDLE.

Configuration
REQ-024 Macro SEG7_READER_HISTORY_EN SHALL, when defined, add output hist  output  16  last four consumed digits, newest in [3:0], shifted left by 4 on each handshake, reset to 0.
REQ-025 Without SEG7_READER_HISTORY_EN the hist port and its registers SHALL not exist; all other behaviour identical.

Verification
REQ-026 STABLE_CYCLES=4, seg_in=7'h24, seg_valid=1 held, digit_ready=1 -> digit=2, digit_valid high exactly one cycle, digit_count=1, no further accept while input unchanged.
REQ-027 seg_in 7'h19 for 3 cycles then 7'h12 for 4 cycles -> only digit=5 accepted; 4 never offered.
REQ-028 seg_in=7'h7F stable 4 cycles -> single pat_err pulse, digit_valid stays 0, digit_count unchanged.
REQ-029 Accept 7'h0E with digit_ready=0 for 10 cycles while seg_in changes to 7'h40 -> digit=F held 10 cycles; after ready, digit=0 offered only after 4 further stable samples.
REQ-030 resetn pulsed low mid-HOLD -> all outputs 0 asynchronously; pending digit never delivered.
REQ-031 300 distinct accepted digits -> digit_count=255; with SEG7_READER_HISTORY_EN, consuming 1,2,3,4 -> hist=16'h1234.

Source files
------------

// File: rtl/seg7_reader.sv
// Seven-segment pattern reader: debounces an active-low segment bus into hex digits
// with a valid/ready handoff. Define SEG7_READER_HISTORY_EN to add the hist output.
module seg7_reader #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [6:0] seg_in,
   input  logic       seg_valid,
   output logic [3:0] digit,
   output logic       digit_valid,
   input  logic       digit_ready,
   output logic       pat_err,
   output logic [7:0] digit_count
`ifdef SEG7_READER_HISTORY_EN
   ,
   output logic [15:0] hist
`endif
);

   // state       | meaning
   // IDLE        | no valid input seen; waiting for seg_valid
   // TRACK       | counting consecutive identical samples of cur_pat
   // HOLD        | digit offered, waiting for consumer handshake
   // WAIT_CHANGE | pattern already handled; waiting for it to change or drop
   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      TRACK       = 2'd1,
      HOLD        = 2'd2,
      WAIT_CHANGE = 2'd3
   } state_t;

   localparam logic [7:0] STABLE_TC = 8'(STABLE_CYCLES);

   state_t     state, state_nxt;
   logic [6:0] cur_pat, cur_pat_nxt;
   logic [7:0] stab_cnt, stab_cnt_nxt;
   logic [3:0] digit_nxt;
   logic       pat_err_nxt;
   logic [7:0] digit_count_nxt;
   logic       eval;
   logic [4:0] dec;
`ifdef SEG7_READER_HISTORY_EN
   logic [15:0] hist_nxt;
`endif

   // {glyph_ok, value}
   function automatic logic [4:0] decode(input logic [6:0] pat);
      case (pat)
         7'h40:   decode = {1'b1, 4'h0};
         7'h79:   decode = {1'b1, 4'h1};
         7'h24:   decode = {1'b1, 4'h2};
         7'h30:   decode = {1'b1, 4'h3};
         7'h19:   decode = {1'b1, 4'h4};
         7'h12:   decode = {1'b1, 4'h5};
         7'h02:   decode = {1'b1, 4'h6};
         7'h78:   decode = {1'b1, 4'h7};
         7'h00:   decode = {1'b1, 4'h8};
         7'h10:   decode = {1'b1, 4'h9};
         7'h08:   decode = {1'b1, 4'hA};
         7'h03:   decode = {1'b1, 4'hB};
         7'h46:   decode = {1'b1, 4'hC};
         7'h21:   decode = {1'b1, 4'hD};
         7'h06:   decode = {1'b1, 4'hE};
         7'h0E:   decode = {1'b1, 4'hF};
         default: decode = {1'b0, 4'h0};
      endcase
   endfunction

   assign dec         = decode(seg_in);
   assign digit_valid = (state == HOLD);

   always_comb begin
      state_nxt       = state;
      cur_pat_nxt     = cur_pat;
      stab_cnt_nxt    = stab_cnt;
      digit_nxt       = digit;
      pat_err_nxt     = 1'b0;
      digit_count_nxt = digit_count;
      eval            = 1'b0;
`ifdef SEG7_READER_HISTORY_EN
      hist_nxt        = hist;
`endif
      case (state)
         IDLE: begin
            if (seg_valid) begin
               cur_pat_nxt  = seg_in;
               stab_cnt_nxt = 8'd1;
               state_nxt    = TRACK;
               eval         = 1'b1;
            end
         end
         TRACK: begin
            if (!seg_valid) begin
               stab_cnt_nxt = 8'd0;
               state_nxt    = IDLE;
            end else if (seg_in != cur_pat) begin
               cur_pat_nxt  = seg_in;
               stab_cnt_nxt = 8'd1;
               eval         = 1'b1;
            end else begin
               stab_cnt_nxt = stab_cnt + 8'd1;
               eval         = 1'b1;
            end
         end
         HOLD: begin
            if (digit_ready) begin
               if (digit_count != 8'hFF) digit_count_nxt = digit_count + 8'd1;
`ifdef SEG7_READER_HISTORY_EN
               hist_nxt = {hist[11:0], digit};
`endif
               state_nxt = WAIT_CHANGE;
            end
         end
         WAIT_CHANGE: begin
            if (!seg_valid) begin
               stab_cnt_nxt = 8'd0;
               state_nxt    = IDLE;
            end else if (seg_in != cur_pat) begin
               cur_pat_nxt  = seg_in;
               stab_cnt_nxt = 8'd1;
               state_nxt    = TRACK;
               eval         = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Acceptance uses the count being written, so a pattern sampled at edge N
      // is offered right after edge N+STABLE_CYCLES-1.
      if (eval && (stab_cnt_nxt == STABLE_TC)) begin
         if (dec[4]) begin
            digit_nxt = dec[3:0];
            state_nxt = HOLD;
         end else begin
            pat_err_nxt = 1'b1;
            state_nxt   = WAIT_CHANGE;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         cur_pat     <= 7'h7F;
         stab_cnt    <= 8'd0;
         digit       <= 4'd0;
         pat_err     <= 1'b0;
         digit_count <= 8'd0;
`ifdef SEG7_READER_HISTORY_EN
         hist        <= 16'd0;
`endif
      end else begin
         state       <= state_nxt;
         cur_pat     <= cur_pat_nxt;
         stab_cnt    <= stab_cnt_nxt;
         digit       <= digit_nxt;
         pat_err     <= pat_err_nxt;
         digit_count <= digit_count_nxt;
`ifdef SEG7_READER_HISTORY_EN
         hist        <= hist_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader: per-cycle vector table plus directed
// sequences for hold/backpressure, mid-HOLD reset and count saturation.
module tb_seg7_reader;

   logic       clock = 1'b0;
   logic       resetn;
   logic [6:0] seg_in;
   logic       seg_valid;
   logic [3:0] digit;
   logic       digit_valid;
   logic       digit_ready;
   logic       pat_err;
   logic [7:0] digit_count;
`ifdef SEG7_READER_HISTORY_EN
   logic [15:0] hist;
`endif

   int checks = 0;
   int errors = 0;

   seg7_reader #(.STABLE_CYCLES(4)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .seg_in      (seg_in),
      .seg_valid   (seg_valid),
      .digit       (digit),
      .digit_valid (digit_valid),
      .digit_ready (digit_ready),
      .pat_err     (pat_err),
      .digit_count (digit_count)
`ifdef SEG7_READER_HISTORY_EN
      ,
      .hist        (hist)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [6:0] seg;
      logic       v;
      logic       r;
      logic [3:0] d;
      logic       dv;
      logic       err;
      logic [7:0] cnt;
   } vec_t;

   vec_t       tbl[$];
   logic [6:0] glyph[16];
   int         model_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic [6:0] s, input logic v, input logic r, input logic [3:0] d,
                      input logic dv, input logic err, input logic [7:0] cnt);
      vec_t x;
      x.seg = s; x.v = v; x.r = r; x.d = d; x.dv = dv; x.err = err; x.cnt = cnt;
      tbl.push_back(x);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      chk("no_err_with_valid", {31'd0, pat_err & digit_valid}, 32'd0);
   endtask

   // Present a pattern with ready high; expect the digit within a bounded window, then consume it.
   task automatic accept(input int val);
      bit seen;
      seg_in      = glyph[val];
      seg_valid   = 1'b1;
      digit_ready = 1'b1;
      seen = 0;
      for (int k = 0; k < 8 && !seen; k++) begin
         step();
         if (digit_valid) seen = 1;
      end
      chk("accept_seen", {31'd0, seen}, 32'd1);
      chk("accept_digit", {28'd0, digit}, val);
      step();
      if (model_cnt < 255) model_cnt++;
      chk("accept_count", {24'd0, digit_count}, model_cnt);
   endtask

   initial begin
      glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      resetn = 1'b0; seg_in = 7'h7F; seg_valid = 1'b0; digit_ready = 1'b0;
      #10;
      chk("rst_digit", {28'd0, digit}, 0);
      chk("rst_dv", {31'd0, digit_valid}, 0);
      chk("rst_err", {31'd0, pat_err}, 0);
      chk("rst_cnt", {24'd0, digit_count}, 0);
      #2 resetn = 1'b1;

      // seg, v, r, digit, dv, err, count (outputs after the edge)
      for (int i = 0; i < 3; i++) add(7'h24, 1, 1, 4'h0, 0, 0, 0);
      add(7'h24, 1, 1, 4'h2, 1, 0, 0);
      for (int i = 0; i < 4; i++) add(7'h24, 1, 1, 4'h2, 0, 0, 1);
      for (int i = 0; i < 3; i++) add(7'h7F, 1, 1, 4'h2, 0, 0, 1);
      add(7'h7F, 1, 1, 4'h2, 0, 1, 1);
      for (int i = 0; i < 2; i++) add(7'h7F, 1, 1, 4'h2, 0, 0, 1);
      for (int i = 0; i < 3; i++) add(7'h19, 1, 1, 4'h2, 0, 0, 1);
      for (int i = 0; i < 3; i++) add(7'h12, 1, 1, 4'h2, 0, 0, 1);
      add(7'h12, 1, 1, 4'h5, 1, 0, 1);
      add(7'h12, 1, 1, 4'h5, 0, 0, 2);
      add(7'h12, 0, 1, 4'h5, 0, 0, 2);
      add(7'h06, 1, 1, 4'h5, 0, 0, 2);
      add(7'h06, 0, 1, 4'h5, 0, 0, 2);
      for (int i = 0; i < 3; i++) add(7'h06, 1, 1, 4'h5, 0, 0, 2);
      add(7'h06, 1, 1, 4'hE, 1, 0, 2);
      add(7'h40, 1, 0, 4'hE, 1, 0, 2);
      add(7'h40, 1, 1, 4'hE, 0, 0, 3);

      foreach (tbl[i]) begin
         seg_in = tbl[i].seg; seg_valid = tbl[i].v; digit_ready = tbl[i].r;
         step();
         if (digit_valid !== tbl[i].dv || pat_err !== tbl[i].err ||
             digit !== tbl[i].d || digit_count !== tbl[i].cnt)
            $display("  vector %0d differs", i);
         chk("vec_dv", {31'd0, digit_valid}, tbl[i].dv);
         chk("vec_err", {31'd0, pat_err}, tbl[i].err);
         chk("vec_digit", {28'd0, digit}, tbl[i].d);
         chk("vec_cnt", {24'd0, digit_count}, tbl[i].cnt);
      end

      // Backpressure: F held while the bus moves to 0, then 0 needs a fresh stable run.
      seg_in = 7'h0E; seg_valid = 1'b1; digit_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin step(); chk("f_wait_dv", {31'd0, digit_valid}, 0); end
      step();
      chk("f_dv", {31'd0, digit_valid}, 1);
      chk("f_digit", {28'd0, digit}, 4'hF);
      seg_in = 7'h40;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("f_hold_dv", {31'd0, digit_valid}, 1);
         chk("f_hold_digit", {28'd0, digit}, 4'hF);
      end
      digit_ready = 1'b1;
      step();
      chk("f_take_dv", {31'd0, digit_valid}, 0);
      chk("f_take_cnt", {24'd0, digit_count}, 4);
      for (int i = 0; i < 3; i++) begin step(); chk("z_wait_dv", {31'd0, digit_valid}, 0); end
      step();
      chk("z_dv", {31'd0, digit_valid}, 1);
      chk("z_digit", {28'd0, digit}, 4'h0);
      step();
      chk("z_cnt", {24'd0, digit_count}, 5);

      // Reset during HOLD drops the pending digit immediately.
      seg_in = 7'h79; digit_ready = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("h_dv", {31'd0, digit_valid}, 1);
      chk("h_digit", {28'd0, digit}, 4'h1);
      #2 resetn = 1'b0;
      #1;
      chk("ar_dv", {31'd0, digit_valid}, 0);
      chk("ar_digit", {28'd0, digit}, 0);
      chk("ar_cnt", {24'd0, digit_count}, 0);
      chk("ar_err", {31'd0, pat_err}, 0);
      @(posedge clock);
      @(negedge clock);
      resetn = 1'b1; seg_valid = 1'b0; digit_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("pr_dv", {31'd0, digit_valid}, 0);
         chk("pr_cnt", {24'd0, digit_count}, 0);
      end

      // Saturation over 300 accepted digits, then history of 1,2,3,4.
      model_cnt = 0;
      for (int i = 0; i < 300; i++) accept(i % 16);
      chk("sat_cnt", {24'd0, digit_count}, 255);
      for (int i = 1; i <= 4; i++) accept(i);
      chk("sat_cnt_hold", {24'd0, digit_count}, 255);
`ifdef SEG7_READER_HISTORY_EN
      chk("hist", {16'd0, hist}, 16'h1234);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
